// File: rtl/booth_mult_pkg.sv
// ---------------------------------------------------------------------------
// booth_mult_pkg
//   Shared constants, the radix-2 Booth opcode type and the recoding
//   function used by the Booth multiplier and its partial-product generator.
// ---------------------------------------------------------------------------
package booth_mult_pkg;

    localparam int WIDTH  = 32;              // operand width
    localparam int PWIDTH = 2 * WIDTH;       // product width
    localparam int SHW    = $clog2(WIDTH);   // width of a partial-product shift index

    typedef enum logic [1:0] {
        BOOTH_ZERO  = 2'd0,
        BOOTH_PLUS  = 2'd1,
        BOOTH_MINUS = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the pair {b_i, b_(i-1)}.
    function automatic booth_op_t booth_encode(input logic [1:0] pair);
        booth_op_t op;
        case (pair)
            2'b01:   op = BOOTH_PLUS;
            2'b10:   op = BOOTH_MINUS;
            default: op = BOOTH_ZERO;   // 00 and 11: run of equal bits
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// ---------------------------------------------------------------------------
// booth_pp_gen
//   One radix-2 Booth partial product: sign-extends the multiplicand to the
//   full product width, selects 0 / +A / -A from the Booth pair, and shifts
//   the selection left by the bit index of the pair.
// Ports
//   a          in   WIDTH   signed multiplicand
//   pair       in   2       {b_i, b_(i-1)}
//   shift_idx  in   SHW     bit position i of the pair
//   pp         out  PWIDTH  shifted partial product
// ---------------------------------------------------------------------------
module booth_pp_gen
    import booth_mult_pkg::*;
(
    input  logic [WIDTH-1:0]  a,
    input  logic [1:0]        pair,
    input  logic [SHW-1:0]    shift_idx,
    output logic [PWIDTH-1:0] pp
);

    logic [PWIDTH-1:0] a_ext;
    logic [PWIDTH-1:0] sel;

    always_comb begin
        a_ext = {{(PWIDTH-WIDTH){a[WIDTH-1]}}, a};
        case (booth_encode(pair))
            BOOTH_PLUS:  sel = a_ext;
            // Negation in full product width, so -(-2^31) is representable.
            BOOTH_MINUS: sel = ~a_ext + {{(PWIDTH-1){1'b0}}, 1'b1};
            default:     sel = '0;
        endcase
        pp = sel << shift_idx;
    end

endmodule

// File: rtl/booth_multiplier32.sv
// ---------------------------------------------------------------------------
// booth_multiplier32
//   Signed 32x32 -> 64-bit multiplier. B is radix-2 Booth recoded into 32
//   partial products that are summed combinationally (modulo 2^64); the sum
//   is registered once into Product.
// Ports
//   clk      in   1   clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   A        in   32  signed multiplicand
//   B        in   32  signed multiplier (Booth recoded)
//   Product  out  64  registered signed product A*B
// Configuration
//   BOOTH_MULT_INPUT_REG_EN: when defined, A and B are first captured in
//   input registers (reset 0), giving 2-cycle latency at full throughput.
//   When undefined, latency is 1 cycle and A/B feed the Booth logic directly.
// ---------------------------------------------------------------------------
module booth_multiplier32
    import booth_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic [PWIDTH-1:0] Product
);

    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;

`ifdef BOOTH_MULT_INPUT_REG_EN
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;

    always_comb begin
        a_d = A;
        b_d = B;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_op = a_q;
    assign b_op = b_q;
`else
    assign a_op = A;
    assign b_op = B;
`endif

    // Appending B[-1]=0 lets pair i be read as b_ext[i+1:i].
    logic [WIDTH:0] b_ext;
    assign b_ext = {b_op, 1'b0};

    logic [WIDTH-1:0][PWIDTH-1:0] pp;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        booth_pp_gen u_pp (
            .a         (a_op),
            .pair      (b_ext[i+1:i]),
            .shift_idx (SHW'(i)),
            .pp        (pp[i])
        );
    end

    logic [PWIDTH-1:0] product_d;
    logic [PWIDTH-1:0] product_q;

    // Linear sum; wraparound modulo 2^64 yields the exact signed product.
    always_comb begin
        product_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            product_d = product_d + pp[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q <= '0;
        end else begin
            product_q <= product_d;
        end
    end

    assign Product = product_q;

endmodule

// File: tb/tb_booth_multiplier32.sv
module tb_booth_multiplier32;

`ifdef BOOTH_MULT_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] Product;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    booth_multiplier32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .Product (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: product of the operands seen at each edge, delayed LAT edges.
    longint m [1:LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= LAT; k++) m[k] <= 0;
        end else begin
            for (int k = 2; k <= LAT; k++) m[k] <= m[k-1];
            m[1] <= longint'($signed(A)) * longint'($signed(B));
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) check("stream", Product, m[LAT]);
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A = a;
        B = b;
    endtask

    // Hand-computed literal expectation after the configured latency.
    task automatic directed(input string name, input logic [31:0] a,
                            input logic [31:0] b, input longint exp);
        drive(a, b);
        repeat (LAT) @(posedge clk);
        #1;
        check(name, Product, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", Product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1;

        directed("12345x6789",   32'd12345,          32'd6789,           64'sd83810205);
        directed("-10000x5",     -32'sd10000,        32'd5,              -64'sd50000);
        directed("32000x-16",    32'd32000,          -32'sd16,           -64'sd512000);
        directed("-25000x-12",   -32'sd25000,        -32'sd12,           64'sd300000);
        directed("max_x_1",      32'h7fff_ffff,      32'd1,              64'sd2147483647);
        directed("min_x_min",    32'h8000_0000,      32'h8000_0000,      64'sd4611686018427387904);
        directed("min_x_max",    32'h8000_0000,      32'h7fff_ffff,      -64'sd4611686016279904256);
        directed("min_x_1",      32'h8000_0000,      32'd1,              -64'sd2147483648);
        directed("max_x_max",    32'h7fff_ffff,      32'h7fff_ffff,      64'sd4611686014132420609);
        directed("zero_x_b",     32'd0,              32'hdead_beef,      64'sd0);
        directed("a_x_zero",     32'h8765_4321,      32'd0,              64'sd0);
        directed("m1_x_m1",      32'hffff_ffff,      32'hffff_ffff,      64'sd1);

        // Mid-stream reset: Product must clear before any further edge.
        drive(32'd7, 32'd9);
        repeat (LAT) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", Product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_edge1", Product, (LAT == 1) ? 64'd63 : 64'd0);
        @(posedge clk);
        #1;
        check("post_reset_edge2", Product, 64'd63);

        // Back-to-back random operands, one pair per cycle.
        for (int n = 0; n < 1000; n++) begin
            drive($urandom, $urandom);
        end
        repeat (LAT + 1) @(negedge clk);
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
